sle_response_checker: RTL and testbench

- Receive-side counterpart to the sequential-logic-element (SLE) stimulus bench.
- Watches the same SLE control and data pins the bench drives (D, EN, ALn, ADn, SLn, SD, LAT) plus the DUT output Q.
- Runs a cycle-accurate golden model, compares it against DUT Q, and reports mismatches, counts and the index of the first failure.
- Synthesizable, so it can be used in simulation benches and on-FPGA self-test wrappers.

---
 rtl/sle_response_checker.sv | 133 +++++++++++++
 tb/tb_sle_response_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sle_response_checker.sv
// sle_response_checker: receive-side golden model for a sequential logic element.
// Tracks the SLE pins (D, EN, ALn, ADn, SLn, SD, LAT), predicts Q each posedge and
// compares it against Q_DUT, reporting per-compare MISMATCH pulses, a saturating
// error count, the compare count and the index of the first failing compare.
//
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   START              one-cycle pulse, begins a run from IDLE or FINISH
//   D..LAT             observed SLE inputs
//   Q_DUT              SLE output under check
//   BUSY / DONE        run in progress / run complete
//   PASS               valid with DONE, no mismatches seen
//   MISMATCH           registered pulse, one per failed compare
//   ERR_CNT            saturating mismatch count
//   CHK_CNT            compares performed in this run
//   FIRST_ERR_IDX      CHK_CNT at first mismatch, all-ones if none
//
// Build option: SLE_CHK_STOP_ON_ERR_EN ends the run on the first mismatch.
module sle_response_checker #(
  parameter int unsigned NUM_CHECKS = 350,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             D,
  input  logic             EN,
  input  logic             ALn,
  input  logic             ADn,
  input  logic             SLn,
  input  logic             SD,
  input  logic             LAT,
  input  logic             Q_DUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             MISMATCH,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] FIRST_ERR_IDX
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t state_q, state_d;
  logic   m_q;
  logic   n_model;
  logic   expected;
  logic   miscmp;
  logic   start_run;

  // Inputs only move on negedge, so latch and flop mode agree at posedge;
  // LAT is observed for trace purposes only.
  logic   lat_unused;
  assign lat_unused = LAT;

  always_comb begin
    n_model   = !ALn ? ~ADn : (EN ? (SLn ? D : SD) : m_q);
    // Async load is already visible on Q before the edge.
    expected  = !ALn ? ~ADn : m_q;
    miscmp    = (state_q == S_RUN) && (Q_DUT != expected);
    start_run = START && ((state_q == S_IDLE) || (state_q == S_FINISH));

    state_d = state_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    PASS    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) state_d = S_PRIME;
      end
      S_PRIME: begin
        BUSY    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (CHK_CNT == LAST_IDX) state_d = S_FINISH;
`ifdef SLE_CHK_STOP_ON_ERR_EN
        if (miscmp) state_d = S_FINISH;
`endif
      end
      S_FINISH: begin
        DONE = 1'b1;
        PASS = (ERR_CNT == '0);
        if (START) state_d = S_PRIME;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q           <= 1'b0;
      MISMATCH      <= 1'b0;
      ERR_CNT       <= '0;
      CHK_CNT       <= '0;
      FIRST_ERR_IDX <= '1;
    end else begin
      m_q      <= n_model;
      MISMATCH <= miscmp;
      if (start_run) begin
        ERR_CNT       <= '0;
        CHK_CNT       <= '0;
        FIRST_ERR_IDX <= '1;
      end else if (state_q == S_RUN) begin
        CHK_CNT <= CHK_CNT + CNT_W'(1);
        if (miscmp) begin
          if (ERR_CNT != ERR_MAX) ERR_CNT <= ERR_CNT + ERR_W'(1);
          if (FIRST_ERR_IDX == '1) FIRST_ERR_IDX <= CHK_CNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_sle_response_checker.sv
// Self-checking bench for sle_response_checker: a reference SLE produces the
// correct Q, a fault schedule decides what Q_DUT shows, and expected checker
// reports are queued and compared by an independent negedge monitor.
module tb_sle_response_checker;

  localparam int NUM_CHECKS = 350;
  localparam int CNT_W      = 16;
  localparam int ERR_W      = 8;
  localparam int ERR_SAT    = 255;
  localparam int NO_ERR     = 65535;

  logic CLK = 1'b0;
  logic RST, START, D, EN, ALn, ADn, SLn, SD, LAT, Q_DUT;
  logic BUSY, DONE, PASS, MISMATCH;
  logic [ERR_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] CHK_CNT, FIRST_ERR_IDX;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int err;
    int chk;
    int first;
    int pass;
  } rec_t;

  rec_t mis_q[$];
  rec_t fin_q[$];
  logic sle_q;

  sle_response_checker #(
    .NUM_CHECKS(NUM_CHECKS),
    .CNT_W(CNT_W),
    .ERR_W(ERR_W)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .D(D), .EN(EN), .ALn(ALn), .ADn(ADn), .SLn(SLn), .SD(SD), .LAT(LAT),
    .Q_DUT(Q_DUT),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .MISMATCH(MISMATCH),
    .ERR_CNT(ERR_CNT), .CHK_CNT(CHK_CNT), .FIRST_ERR_IDX(FIRST_ERR_IDX)
  );

  always #5 CLK = ~CLK;

  // Reference SLE: async load dominates, then enabled sync-load/data, else hold.
  function automatic logic sle_next(input logic q);
    if (!ALn) return !ADn;
    if (!EN) return q;
    return SLn ? D : SD;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) sle_q <= 1'b0;
    else     sle_q <= sle_next(sle_q);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_pass", int'(PASS), 0);
    check("rst_mismatch", int'(MISMATCH), 0);
    check("rst_err_cnt", int'(ERR_CNT), 0);
    check("rst_chk_cnt", int'(CHK_CNT), 0);
    check("rst_first_err_idx", int'(FIRST_ERR_IDX), NO_ERR);
  endtask

  // Monitor: pops expected reports whenever the checker emits one.
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    rec_t r;
    if (RST) begin
      done_prev = 1'b0;
    end else begin
      if (MISMATCH) begin
        if (mis_q.size() == 0) check("unexpected_mismatch_pulse", 1, 0);
        else begin
          r = mis_q.pop_front();
          check("pulse_err_cnt", int'(ERR_CNT), r.err);
          check("pulse_chk_cnt", int'(CHK_CNT), r.chk);
        end
      end
      if (DONE && !done_prev) begin
        if (fin_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          r = fin_q.pop_front();
          check("missing_mismatch_pulses", mis_q.size(), 0);
          check("final_err_cnt", int'(ERR_CNT), r.err);
          check("final_chk_cnt", int'(CHK_CNT), r.chk);
          check("final_first_err_idx", int'(FIRST_ERR_IDX), r.first);
          check("final_pass", int'(PASS), r.pass);
        end
      end
      done_prev = DONE;
    end
  end

  task automatic drive_pins(input int mode, input int idx);
    D   = 1'($urandom);
    EN  = ($urandom % 4) != 0;
    ALn = ($urandom % 4) != 0;
    ADn = 1'($urandom);
    SLn = 1'($urandom);
    SD  = 1'($urandom);
    LAT = 1'($urandom);
    case (mode)
      1: if (idx < 50) ALn = 1'b0;
      2: if (idx < 10) begin
        ALn = 1'b1; LAT = 1'b0; EN = 1'b1; SLn = 1'b0; SD = 1'b1; D = 1'b0;
      end
      3: begin
        if (idx < 5) begin
          ALn = 1'b1; LAT = 1'b0; EN = 1'b1; SLn = 1'b0; SD = 1'b1; D = 1'b0;
        end else if (idx < 21) begin
          ALn = 1'b1; EN = 1'b0; D = ((idx % 2) == 1);
        end else if (idx == 21) begin
          ALn = 1'b0; ADn = 1'b1;
        end
      end
      4: begin
        ALn = 1'b1; EN = 1'b1; SLn = 1'b1; D = ($urandom % 8) != 0;
      end
      default: ;
    endcase
  endtask

  function automatic logic apply_fault(input int mode, input int idx, input logic qc);
    case (mode)
      2:       return (idx == 3) ? !qc : qc;
      4:       return 1'b0;
      5:       return !qc;
      6:       return (($urandom % 16) == 0) ? !qc : qc;
      7:       return (idx == NUM_CHECKS - 1) ? !qc : qc;
      8:       return (idx == 10) ? !qc : qc;
      default: return qc;
    endcase
  endfunction

  // One run: START, PRIME cycle, then compares; abort_at >= 0 pulses RST mid-run.
  task automatic do_run(input int mode, input int abort_at);
    int   errs    = 0;
    int   first   = NO_ERR;
    int   last    = NUM_CHECKS;
    bit   stopped = 1'b0;
    logic qc;
    rec_t r;

    @(negedge CLK);
    START = 1'b1;
    drive_pins(mode, -2);
    Q_DUT = 1'($urandom);
    @(negedge CLK);
    START = 1'b0;
    drive_pins(mode, -1);
    check("prime_busy", int'(BUSY), 1);
    check("prime_chk_cnt", int'(CHK_CNT), 0);
    check("prime_err_cnt", int'(ERR_CNT), 0);
    check("prime_first_err_idx", int'(FIRST_ERR_IDX), NO_ERR);

    for (int idx = 0; idx < NUM_CHECKS; idx++) begin
      @(negedge CLK);
      if (idx == abort_at) begin
        check("abort_chk_cnt", int'(CHK_CNT), idx);
        #2 RST = 1'b1;
        #1 check_reset_outputs();
        mis_q.delete();
        fin_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
      drive_pins(mode, idx);
      if (mode == 6) START = ($urandom % 8) == 0;
      qc    = !ALn ? !ADn : sle_q;
      Q_DUT = apply_fault(mode, idx, qc);
      if (Q_DUT != qc) begin
        errs++;
        if (first == NO_ERR) first = idx;
        r.err   = (errs > ERR_SAT) ? ERR_SAT : errs;
        r.chk   = idx + 1;
        r.first = first;
        r.pass  = 0;
        mis_q.push_back(r);
`ifdef SLE_CHK_STOP_ON_ERR_EN
        stopped = 1'b1;
        last    = idx + 1;
`endif
      end
      @(posedge CLK);
      if (stopped) break;
    end

    r.err   = (errs > ERR_SAT) ? ERR_SAT : errs;
    r.chk   = last;
    r.first = first;
    r.pass  = (errs == 0) ? 1 : 0;
    fin_q.push_back(r);

    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      START = 1'b0;
      drive_pins(0, 0);
      #1;
      if (fin_q.size() == 0) break;
    end
    if (fin_q.size() != 0) begin
      check("done_timeout", 0, 1);
      fin_q.delete();
      mis_q.delete();
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; D = 1'b0; EN = 1'b0; ALn = 1'b1; ADn = 1'b1;
    SLn = 1'b1; SD = 1'b0; LAT = 1'b0; Q_DUT = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs();
    RST = 1'b0;

    do_run(1, -1);   // async-load heavy, clean
    do_run(2, -1);   // directed sync load to 1, fault at compare 3
    do_run(3, -1);   // EN=0 hold, then async load to 0
    do_run(4, -1);   // Q tied low
    do_run(5, -1);   // every compare fails: saturation
    do_run(0, 100);  // reset mid-run
    do_run(0, -1);   // clean restart after reset
    do_run(6, -1);   // random faults, START noise during RUN
    do_run(7, -1);   // only the final compare fails
    do_run(8, -1);   // fault at compare 10
    do_run(6, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
